button_debouncer: RTL and testbench

- Debounces one raw mechanical push-button input.
- Produces a clean level output and a single-cycle rising-edge pulse.
- One instance per button. Sits between the board pins and the Morse-code entry logic, which consumes only the pulse.
- The consumer samples on the falling clock edge, so the pulse is a full-clock-cycle registered strobe.

---
 rtl/button_debouncer.sv | 101 ++++++++++
 tb/tb_button_debouncer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes one raw button level, accepts a new
// level only after it has persisted for STABLE_CYCLES consecutive clocks,
// and emits a one-cycle registered strobe on every debounced rising edge.
//
// Optional feature: define DEBOUNCE_NEGEDGE_EN to add btn_stable_negedge,
// a one-cycle strobe on every debounced falling edge. Without the macro the
// module has exactly five ports.
module button_debouncer #(
  parameter int STABLE_CYCLES  = 1000000,
  parameter int SYNC_STAGES    = 2,
  parameter int BTN_ACTIVE_LOW = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_stable,
  output logic btn_stable_posedge
`ifdef DEBOUNCE_NEGEDGE_EN
  ,
  output logic btn_stable_negedge
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                   btn_in;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
`ifdef DEBOUNCE_NEGEDGE_EN
  logic             fall_q, fall_d;
`endif

  // Pull-up buttons are inverted before synchronization so the rest of the
  // logic always sees "pressed" as 1.
  assign btn_in = (BTN_ACTIVE_LOW != 0) ? ~btn : btn;
  assign sample = sync_q[SYNC_STAGES-1];

  // Metastability synchronizer: the only logic that touches the raw pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  // Persistence counter: counts while the sample disagrees with the stable
  // level, restarts on any agreement, and flips the level at terminal count.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
`ifdef DEBOUNCE_NEGEDGE_EN
    fall_d   = 1'b0;
`endif
    if (sample != stable_q) begin
      if (cnt_q == CNT_TC) begin
        stable_d = sample;
        rise_d   = sample;
`ifdef DEBOUNCE_NEGEDGE_EN
        fall_d   = ~sample;
`endif
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Counter, debounced level and edge strobes all update on the same edge,
  // so each strobe coincides exactly with the level change it marks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
`ifdef DEBOUNCE_NEGEDGE_EN
      fall_q   <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
`ifdef DEBOUNCE_NEGEDGE_EN
      fall_q   <= fall_d;
`endif
    end
  end

  assign btn_stable         = stable_q;
  assign btn_stable_posedge = rise_q;
`ifdef DEBOUNCE_NEGEDGE_EN
  assign btn_stable_negedge = fall_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with STABLE_CYCLES=4, SYNC_STAGES=2. Two
// instances run side by side: an active-high one on btn and an active-low
// one on ~btn, both expected to match the same reference model.
module tb_button_debouncer;

  localparam int SC = 4;
  localparam int SS = 2;
  localparam int HL = SS + SC - 1;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic btn_n;
  logic st_a, pos_a, st_b, pos_b;
`ifdef DEBOUNCE_NEGEDGE_EN
  logic neg_a, neg_b;
`endif

  int errors = 0;
  int checks = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  // Reference model: history of btn levels seen at past rising edges.
  // The synchronized sample at edge n is btn from SS edges earlier; the
  // level flips when the last SC samples all differ from it.
  bit hist [HL];
  bit m_st, m_pos, m_neg;

  assign btn_n = ~btn;

  always #5 clk = ~clk;

  button_debouncer #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS), .BTN_ACTIVE_LOW(0)) dut_a (
    .clk                (clk),
    .rst                (rst),
    .btn                (btn),
    .btn_stable         (st_a),
    .btn_stable_posedge (pos_a)
`ifdef DEBOUNCE_NEGEDGE_EN
    ,
    .btn_stable_negedge (neg_a)
`endif
  );

  button_debouncer #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS), .BTN_ACTIVE_LOW(1)) dut_b (
    .clk                (clk),
    .rst                (rst),
    .btn                (btn_n),
    .btn_stable         (st_b),
    .btn_stable_posedge (pos_b)
`ifdef DEBOUNCE_NEGEDGE_EN
    ,
    .btn_stable_negedge (neg_b)
`endif
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit all_diff;
    if (!rst) begin
      foreach (hist[i]) hist[i] = 1'b0;
      m_st  = 1'b0;
      m_pos = 1'b0;
      m_neg = 1'b0;
    end else begin
      all_diff = 1'b1;
      for (int i = SS - 1; i < HL; i++)
        if (hist[i] == m_st) all_diff = 1'b0;
      m_pos = all_diff && !m_st;
      m_neg = all_diff && m_st;
      if (all_diff) m_st = !m_st;
      for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = btn;
    end
  endtask

  // One clock: model advances on the rising edge, outputs compared on the
  // following falling edge; callers change inputs only after this returns.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (pos_a === 1'b1) pulses_a++;
    if (pos_b === 1'b1) pulses_b++;
    check("stable_ah", st_a, m_st);
    check("posedge_ah", pos_a, m_pos);
    check("stable_al", st_b, m_st);
    check("posedge_al", pos_b, m_pos);
`ifdef DEBOUNCE_NEGEDGE_EN
    check("negedge_ah", neg_a, m_neg);
    check("negedge_al", neg_b, m_neg);
    check("no_both_edges", pos_a & neg_a, 1'b0);
`endif
  endtask

  task automatic hold(input logic level, input int n);
    btn = level;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Counts cycles until the active-high instance reports a stable high,
  // bounded by budget, then checks the count lies in [lo, hi].
  task automatic expect_rise(input string tag, input int lo, input int hi);
    int n;
    n = 0;
    while (st_a !== 1'b1 && n < hi + 3) begin
      cyc();
      n++;
    end
    check(tag, (n >= lo) && (n <= hi), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    btn = 1'b1;
    rst = 1'b0;
    foreach (hist[i]) hist[i] = 1'b0;
    m_st = 1'b0; m_pos = 1'b0; m_neg = 1'b0;

    // Reset held with button pressed: outputs must stay low.
    for (int i = 0; i < 10; i++) cyc();
    check("reset_stable", st_a, 1'b0);

    // Release reset with button still pressed: one debounced rise, one pulse.
    p0 = pulses_a;
    rst = 1'b1;
    expect_rise("reset_release_latency", SS + SC - 1, SS + SC + 1);
    hold(1'b1, 10);
    check("reset_release_one_pulse", (pulses_a - p0) == 1, 1'b1);

    // Release: falls without any rising pulse.
    p0 = pulses_a;
    hold(1'b0, 12);
    check("release_low", st_a, 1'b0);
    check("release_no_pulse", (pulses_a - p0) == 0, 1'b1);

    // Clean press held 20 cycles.
    p0 = pulses_a;
    btn = 1'b1;
    expect_rise("press_latency", SS + SC - 1, SS + SC + 1);
    hold(1'b1, 20);
    check("press_one_pulse", (pulses_a - p0) == 1, 1'b1);
    check("press_one_pulse_al", (pulses_b - p0) == 1, 1'b1);
    hold(1'b0, 12);

    // Bounce 1,0,1,0 of 3 cycles each, then settle high.
    p0 = pulses_a;
    hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 3);
    check("bounce_no_change", st_a, 1'b0);
    check("bounce_no_pulse", (pulses_a - p0) == 0, 1'b1);
    btn = 1'b1;
    expect_rise("bounce_latency", SS + SC - 1, SS + SC + 1);
    hold(1'b1, 8);
    check("bounce_one_pulse", (pulses_a - p0) == 1, 1'b1);
    hold(1'b0, 12);

    // Mid-count reset discards the partial count.
    p0 = pulses_a;
    hold(1'b1, 3);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    expect_rise("midcount_reset_latency", SS + SC - 1, SS + SC + 1);
    hold(1'b1, 6);
    check("midcount_one_pulse", (pulses_a - p0) == 1, 1'b1);
    hold(1'b0, 12);

    // Randomized levels and hold times, with occasional resets.
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b0;
        cyc();
        rst = 1'b1;
      end
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 9));
    end
    hold(1'b0, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
